// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS front-end PC sequencer.
// Contents:
//   - state encoding: BOOT, RUN, WAIT
//   - DEFAULT_RESET_VECTOR: PC value after reset
//   - redir_src_e: where the next PC comes from
//   - word_align(): clears bits [1:0] of a target address
package pipe_pkg;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_PEND
  } redir_src_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect (branch or jump target) that arrived while the fetch was
// stalled, so it can be applied once instruction memory is ready again.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   latch_en_i         fetch is stalled this cycle; capture arriving redirects
//   consume_i          PC is written this cycle; pending redirect is used up
//   br_i/br_target_i   taken branch from EX
//   jmp_i/jmp_target_i jump from ID
//   pend_valid_o       a redirect is pending
//   pend_target_o      word-aligned pending target
module pc_redirect_latch
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        latch_en_i,
  input  logic        consume_i,
  input  logic        br_i,
  input  logic [31:0] br_target_i,
  input  logic        jmp_i,
  input  logic [31:0] jmp_target_i,
  output logic        pend_valid_o,
  output logic [31:0] pend_target_o
);

  logic        pend_valid_q, pend_valid_d;
  logic        pend_is_br_q, pend_is_br_d;
  logic [31:0] pend_target_q, pend_target_d;

  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_is_br_d  = pend_is_br_q;
    pend_target_d = pend_target_q;
    if (consume_i) begin
      pend_valid_d = 1'b0;
      pend_is_br_d = 1'b0;
    end else if (latch_en_i) begin
      if (br_i) begin
        // A branch comes from an older instruction, so it replaces anything.
        pend_valid_d  = 1'b1;
        pend_is_br_d  = 1'b1;
        pend_target_d = word_align(br_target_i);
      end else if (jmp_i && !(pend_valid_q && pend_is_br_q)) begin
        pend_valid_d  = 1'b1;
        pend_is_br_d  = 1'b0;
        pend_target_d = word_align(jmp_target_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_valid_q  <= 1'b0;
      pend_is_br_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_is_br_q  <= pend_is_br_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pend_valid_o  = pend_valid_q;
  assign pend_target_o = pend_target_q;

endmodule

// File: rtl/pc_sched.sv
// Next-PC sequencer for the 5-stage MIPS pipeline.
// Selects the value loaded into the PC (branch, jump, pending redirect, PC+4
// or the reset vector), drives the PC write enable and the IF/ID and ID/EX
// hold/flush controls, rides out instruction-memory wait states and raises a
// sticky fetch_err after FETCH_TIMEOUT consecutive not-ready cycles.
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics
// (taken redirects do not flush IF/ID; a branch flushes ID/EX only on
// load_use).
// Ports:
//   clk, PCReSet_n          clock, synchronous active-low reset
//   PC                      current PC register value
//   imem_ready              fetch at PC completes this cycle
//   load_use                load-use hazard on the ID instruction
//   br_taken, br_target     taken branch resolved in EX
//   jmp, jmp_target         j/jal/jr decoded in ID
//   PCNext, isPCWrite       PC data input and write enable
//   IFIDWrite, IFIDFlush    IF/ID enable and bubble insert
//   IDEXFlush               ID/EX bubble insert
//   fetch_err               sticky fetch-timeout flag
module pc_sched
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR  = DEFAULT_RESET_VECTOR,
  parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        PCReSet_n,
  input  logic [31:0] PC,
  input  logic        imem_ready,
  input  logic        load_use,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic [31:0] PCNext,
  output logic        isPCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        fetch_err
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DelaySlot = 1'b1;
`else
  localparam bit DelaySlot = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        fetch_err_q, fetch_err_d;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        latch_en;
  logic        pc_we;
  redir_src_e  src;
  logic [31:0] sel_pc;

  pc_redirect_latch u_redirect_latch (
    .clk_i         (clk),
    .rst_ni        (PCReSet_n),
    .latch_en_i    (latch_en),
    .consume_i     (pc_we),
    .br_i          (br_taken),
    .br_target_i   (br_target),
    .jmp_i         (jmp),
    .jmp_target_i  (jmp_target),
    .pend_valid_o  (pend_valid),
    .pend_target_o (pend_target)
  );

  // A jump waiting on a load-use stall is ignored; ID reissues it next cycle.
  always_comb begin
    src = SRC_SEQ;
    if (br_taken)                 src = SRC_BR;
    else if (jmp && !load_use)    src = SRC_JMP;
    else if (pend_valid)          src = SRC_PEND;
  end

  always_comb begin
    unique case (src)
      SRC_BR:   sel_pc = word_align(br_target);
      SRC_JMP:  sel_pc = word_align(jmp_target);
      SRC_PEND: sel_pc = pend_target;
      default:  sel_pc = PC + 32'd4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    PCNext     = sel_pc;
    pc_we      = 1'b0;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    latch_en   = 1'b0;
    case (state_q)
      RUN, WAIT: begin
        if (imem_ready) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
          if (src == SRC_BR) begin
            pc_we     = 1'b1;
            IFIDWrite = 1'b1;
            IFIDFlush = !DelaySlot;
            IDEXFlush = DelaySlot ? load_use : 1'b1;
          end else if (load_use) begin
            // One-cycle bubble; PC and IF/ID hold, pending redirect kept.
            IDEXFlush = 1'b1;
          end else begin
            pc_we     = 1'b1;
            IFIDWrite = 1'b1;
            // The instruction fetched at PC is wrong-path after a redirect.
            IFIDFlush = (src != SRC_SEQ) && !DelaySlot;
          end
        end else begin
          state_d    = WAIT;
          IFIDFlush  = 1'b1;
          latch_en   = 1'b1;
          wait_cnt_d = (state_q == RUN)     ? 8'd1 :
                       (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
        end
      end
      default: begin
        // BOOT, and recovery from the unused encoding.
        PCNext    = RESET_VECTOR;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        state_d   = RUN;
      end
    endcase
    fetch_err_d = fetch_err_q | (wait_cnt_d >= FETCH_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (!PCReSet_n) begin
      state_q     <= BOOT;
      wait_cnt_q  <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign isPCWrite = pc_we;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_pc_sched.sv
module tb_pc_sched;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam logic [31:0] RV = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_q = RV;
  logic        imem_ready = 1'b1, load_use = 1'b0, br_taken = 1'b0, jmp = 1'b0;
  logic [31:0] br_target = 32'h0, jmp_target = 32'h0;
  logic [31:0] PCNext;
  logic        isPCWrite, IFIDWrite, IFIDFlush, IDEXFlush, fetch_err;

  always #5 clk = ~clk;

  pc_sched dut (
    .clk        (clk),
    .PCReSet_n  (rst_n),
    .PC         (pc_q),
    .imem_ready (imem_ready),
    .load_use   (load_use),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .PCNext     (PCNext),
    .isPCWrite  (isPCWrite),
    .IFIDWrite  (IFIDWrite),
    .IFIDFlush  (IFIDFlush),
    .IDEXFlush  (IDEXFlush),
    .fetch_err  (fetch_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference model: a boot flag, a consecutive-miss counter, a sticky error
  // and at most one remembered redirect (with whether it came from a branch).
  typedef struct packed {
    logic [31:0] next;
    logic        wr, ifidw, ifidf, idexf, err;
  } exp_t;

  logic        model_valid = 1'b0;
  logic        m_boot = 1'b1, m_err = 1'b0, m_pv = 1'b0, m_pbr = 1'b0;
  logic [31:0] m_pt = 32'h0;
  int          m_miss = 0;

  function automatic exp_t model_out(input logic boot, input logic pv, input logic [31:0] pt,
                                     input logic err, input logic br, input logic [31:0] brt,
                                     input logic j, input logic [31:0] jt, input logic lu,
                                     input logic rdy, input logic [31:0] pc);
    exp_t e;
    logic [31:0] tgt;
    if (br)            tgt = brt & ~32'h3;
    else if (j && !lu) tgt = jt & ~32'h3;
    else if (pv)       tgt = pt;
    else               tgt = pc + 32'd4;
    if (boot)      e = '{RV, 1'b0, 1'b0, 1'b1, 1'b1, err};
    else if (!rdy) e = '{tgt, 1'b0, 1'b0, 1'b1, 1'b0, err};
    else if (br)   e = '{tgt, 1'b1, 1'b1, !DS, DS ? lu : 1'b1, err};
    else if (lu)   e = '{tgt, 1'b0, 1'b0, 1'b0, 1'b1, err};
    else           e = '{tgt, 1'b1, 1'b1, (j || pv) && !DS, 1'b0, err};
    return e;
  endfunction

  exp_t exp_o;
  assign exp_o = model_out(m_boot, m_pv, m_pt, m_err, br_taken, br_target, jmp, jmp_target,
                           load_use, imem_ready, pc_q);

  always @(posedge clk) begin
    if (!rst_n) begin
      model_valid <= 1'b1;
      m_boot <= 1'b1;
      m_err  <= 1'b0;
      m_pv   <= 1'b0;
      m_pbr  <= 1'b0;
      m_miss <= 0;
      pc_q   <= RV;
    end else if (model_valid) begin
      if (m_boot) begin
        m_boot <= 1'b0;
      end else if (!imem_ready) begin
        m_miss <= (m_miss >= 255) ? 255 : m_miss + 1;
        if (m_miss + 1 >= 255) m_err <= 1'b1;
        if (br_taken) begin
          m_pv <= 1'b1; m_pbr <= 1'b1; m_pt <= br_target & ~32'h3;
        end else if (jmp && !(m_pv && m_pbr)) begin
          m_pv <= 1'b1; m_pbr <= 1'b0; m_pt <= jmp_target & ~32'h3;
        end
      end else begin
        m_miss <= 0;
        if (exp_o.wr) begin m_pv <= 1'b0; m_pbr <= 1'b0; end
      end
      if (exp_o.wr) pc_q <= exp_o.next;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    #2;
    if (model_valid) begin
      check("PCNext",    PCNext,    exp_o.next);
      check("isPCWrite", isPCWrite, exp_o.wr);
      check("IFIDWrite", IFIDWrite, exp_o.ifidw);
      check("IFIDFlush", IFIDFlush, exp_o.ifidf);
      check("IDEXFlush", IDEXFlush, exp_o.idexf);
      check("fetch_err", fetch_err, exp_o.err);
    end
  end

  task automatic cyc(input logic br, input logic [31:0] brt, input logic j,
                     input logic [31:0] jt, input logic lu, input logic rdy);
    @(negedge clk);
    rst_n = 1'b1; br_taken = br; br_target = brt; jmp = j; jmp_target = jt;
    load_use = lu; imem_ready = rdy;
    #3;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; br_taken = 1'b0; jmp = 1'b0; load_use = 1'b0; imem_ready = 1'b1;
      #3;
    end
  endtask

  initial begin
    // Reset and boot.
    reset_cycles(3);
    check("rst_pcnext", PCNext, 32'h0000_3000);
    check("rst_we", isPCWrite, 1'b0);
    idle();
    check("boot_we", isPCWrite, 1'b0);
    check("boot_ifidf", IFIDFlush, 1'b1);
    check("boot_idexf", IDEXFlush, 1'b1);
    idle();
    check("seq1", PCNext, 32'h0000_3004);
    check("seq1_we", isPCWrite, 1'b1);
    idle();
    check("seq2", PCNext, 32'h0000_3008);
    idle();
    idle();
    // PC is now 0x3010: taken branch with unaligned target.
    cyc(1'b1, 32'h0000_3102, 1'b0, 32'h0, 1'b0, 1'b1);
    check("br_pcnext", PCNext, 32'h0000_3100);
    check("br_we", isPCWrite, 1'b1);
    check("br_ifidf", IFIDFlush, DS ? 1'b0 : 1'b1);
    check("br_idexf", IDEXFlush, 1'b1);
    // Jump under load-use, then released.
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b1, 1'b1);
    check("lu_we", isPCWrite, 1'b0);
    check("lu_ifidw", IFIDWrite, 1'b0);
    check("lu_idexf", IDEXFlush, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b0, 1'b1);
    check("jmp_pcnext", PCNext, 32'h0000_4000);
    // Stalled fetch: jump then branch arrive, branch must win.
    for (int i = 0; i < 4; i++) begin
      cyc(i == 2, 32'h0000_6000, i == 1, 32'h0000_5000, 1'b0, 1'b0);
      check("wait_we", isPCWrite, 1'b0);
      check("wait_ifidf", IFIDFlush, 1'b1);
    end
    idle();
    check("pend_pcnext", PCNext, 32'h0000_6000);
    check("pend_we", isPCWrite, 1'b1);
    idle();
    check("pend_cleared", PCNext, 32'h0000_6004);
    // Wrap-around.
    cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    idle();
    check("wrap", PCNext, 32'h0000_0000);
    // Fetch timeout.
    for (int i = 0; i < 255; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("err_before", fetch_err, 1'b0);
    idle();
    check("err_set", fetch_err, 1'b1);
    repeat (3) idle();
    check("err_sticky", fetch_err, 1'b1);
    reset_cycles(1);
    idle();
    check("err_cleared", fetch_err, 1'b0);
    // Randomized traffic checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 299) != 0);
      imem_ready = ($urandom_range(0, 9) < 8);
      br_taken   = ($urandom_range(0, 9) == 0);
      jmp        = ($urandom_range(0, 19) < 3);
      load_use   = ($urandom_range(0, 19) < 3);
      br_target  = $urandom;
      jmp_target = $urandom;
    end
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sched.md
Name: pc_sched

Overview:
- Next-PC sequencer for the 5-stage MIPS pipeline. Each cycle it picks the value loaded into the PC register: sequential PC+4, branch target from EX, jump/jr target from ID, or the reset vector.
- Drives the PC write enable and the IF/ID and ID/EX flush/hold controls.
- Absorbs instruction-memory wait states and latches redirects that arrive while a fetch is stalled.

Parameters:
- RESET_VECTOR, 32'h0000_3000, PC value after reset; the PC register's own reset value.
- FETCH_TIMEOUT, 8'd255, max consecutive imem-not-ready cycles before fetch_err is set.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- PCReSet_n  in  1  reset, synchronous, active-low.
- PC  in  32  current PC register value.
- imem_ready  in  1  fetch at PC completes this cycle.
- load_use  in  1  hazard unit: ID instruction needs a load result still in EX.
- br_taken  in  1  branch in EX resolved taken.
- br_target  in  32  branch target from EX.
- jmp  in  1  j/jal/jr decoded in ID.
- jmp_target  in  32  jump target from ID.
- PCNext  out  32  value presented to the PC data input.
- isPCWrite  out  1  PC write enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  IF/ID register becomes bubble.
- IDEXFlush  out  1  ID/EX register becomes bubble.
- fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- All outputs are registered-state-derived combinational. All targets have bits [1:0] forced to 0.
- Reset (PCReSet_n=0 at a clock edge): state=BOOT, pend_valid=0, wait_cnt=0, fetch_err=0.
  - Reset outputs: PCNext=RESET_VECTOR, isPCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1.
  - Reset mid-operation discards any pending redirect.
- States: BOOT, RUN, WAIT.
  - BOOT: one cycle; outputs as in reset; goes to RUN unconditionally.
  - RUN: normal issue. WAIT: imem not ready.
- Redirect select, priority high→low:
  1. br_taken (EX, older instruction).
  2. jmp, only when load_use=0.
  3. Pending latched redirect.
  4. PC+4 (32-bit wrap, 32'hFFFF_FFFC+4=0).
- RUN, imem_ready=1:
  - isPCWrite=1, PCNext=selected value.
  - br_taken: IFIDFlush=1, IDEXFlush=1.
  - jmp: IFIDFlush=1.
  - load_use without br_taken: isPCWrite=0, IFIDWrite=0, IDEXFlush=1 (one-cycle bubble).
  - A pending redirect is consumed (pend_valid cleared).
- RUN, imem_ready=0: isPCWrite=0, IFIDWrite=0, IFIDFlush=1; go to WAIT, wait_cnt=1.
- WAIT:
  - isPCWrite=0, IFIDWrite=0, IFIDFlush=1, wait_cnt increments.
  - A br_taken or jmp arriving now is latched into pend_target with pend_valid=1.
  - A later br_taken overwrites a pending jmp; a jmp never overwrites a pending branch.
  - On imem_ready=1: behaves as RUN with imem_ready=1, wait_cnt cleared, back to RUN.
- wait_cnt saturates. When it reaches FETCH_TIMEOUT, fetch_err is set and held until reset; sequencing continues.
- Simultaneous br_taken and jmp: branch wins, both flushes asserted, jmp dropped.
- Simultaneous br_taken and load_use: branch wins, PC written, IFIDWrite ignored because flushed.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: MIPS delay-slot semantics.
  - Taken branch or jump does not assert IFIDFlush; the slot instruction proceeds.
  - Branch still asserts IDEXFlush only if load_use=1.
- Undefined: flushes exactly as in Behaviour.

Decomposition:
- Shared package pipe_pkg: state encoding (BOOT=2'd0, RUN=2'd1, WAIT=2'd2), RESET_VECTOR default, redirect-source enum (SRC_SEQ, SRC_BR, SRC_JMP, SRC_PEND).
- One sub-module: pc_redirect_latch, holding pend_valid/pend_target and the overwrite priority. FSM and select logic stay in pc_sched.

Test Plan:
- Reset held 3 cycles, release, imem_ready=1 → cycle0 isPCWrite=0 with flushes; from cycle1 PCNext=PC+4 (0x3000→0x3004→0x3008).
- PC=0x3010, br_taken=1, br_target=0x3102 → PCNext=0x3100, isPCWrite=1, IFIDFlush=1, IDEXFlush=1 (IFIDFlush=0 with BRANCH_DELAY_SLOT_EN).
- load_use=1 and jmp=1 with target 0x4000 → isPCWrite=0, IFIDWrite=0, IDEXFlush=1. Next cycle load_use=0, jmp=1 → PCNext=0x4000.
- imem_ready=0 for 4 cycles with jmp=1 (0x5000) in cycle 2 and br_taken=1 (0x6000) in cycle 3 → PC held; on ready PCNext=0x6000, pend_valid cleared.
- imem_ready=0 for 255 cycles → fetch_err=1, stays 1 after ready returns, cleared only by PCReSet_n=0.
- PC=0xFFFF_FFFC, no redirect → PCNext=0x0000_0000.
